// File: rtl/hw_input_conditioner.sv
// -----------------------------------------------------------------------------
// hw_input_conditioner
//
// Front end for the hardware-value decoder. Four raw push-buttons and four
// slide switches are synchronised, debounced and turned into discrete events.
// Events are queued as pending bits and handed to the decoder one at a time as
// a one-hot hardware_value under a valid/ack handshake.
//
// Optional feature macro: HW_INPUT_AUTO_REPEAT_EN
//   defined   : a held button re-issues its press event every REPEAT_CYCLES
//   undefined : exactly one event per press
//
// Ports:
//   clk            in   rising-edge system clock
//   reset          in   synchronous, active-high; clears all state
//   raw_btn[3:0]   in   asynchronous buttons [0]=wb [1]=sb [2]=eb [3]=nb
//   raw_sw[3:0]    in   asynchronous switches, [n]=swn
//   hw_ack         in   decoder has consumed hardware_value
//   hardware_value out  one-hot event: b0 wb, b1 sb, b2 eb, b3 nb,
//                       b4 sw3, b5 sw2, b6 sw1, b7 sw0; 0 when not valid
//   hw_valid       out  hardware_value holds an event
//   sw_level[3:0]  out  debounced switch levels
//   overrun        out  sticky; an event hit an already-pending bit
// -----------------------------------------------------------------------------
module hw_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16,
   parameter int REPEAT_CYCLES   = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] raw_btn,
   input  logic [3:0] raw_sw,
   input  logic       hw_ack,
   output logic [7:0] hardware_value,
   output logic       hw_valid,
   output logic [3:0] sw_level,
   output logic       overrun
);

   // Elaboration-time legality check of the configuration.
   generate
      if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535) || (REPEAT_CYCLES < 1) ||
          (longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CNT_W)) ||
          (longint'(REPEAT_CYCLES - 1) >= (longint'(1) << CNT_W))) begin : g_bad_params
         $error("hw_input_conditioner: illegal DEBOUNCE_CYCLES / REPEAT_CYCLES / CNT_W");
      end
   endgenerate

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Input index: [3:0] buttons, [7:4] switches sw0..sw3.
   logic [7:0] raw_all;
   logic [7:0] stable_all;
   logic [7:0] stable_dly_reg;
   logic [7:0] edge_ev;
   logic [7:0] rep_ev;

   assign raw_all = {raw_sw, raw_btn};

   // ---------------------------------------------------------------- debounce
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_in
         logic             s1_reg;
         logic             s2_reg;
         logic             stable_reg;
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               s1_reg     <= 1'b0;
               s2_reg     <= 1'b0;
               stable_reg <= 1'b0;
               cnt_reg    <= '0;
            end else begin
               s1_reg <= raw_all[gi];
               s2_reg <= s1_reg;
               // Any matching cycle restarts the count, so only an unbroken
               // run of DEBOUNCE_CYCLES mismatches flips the stable value.
               if (s2_reg == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  stable_reg <= s2_reg;
                  cnt_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign stable_all[gi] = stable_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_dly_reg <= '0;
      end else begin
         stable_dly_reg <= stable_all;
      end
   end

   assign sw_level = stable_all[7:4];

   // ------------------------------------------------------------------ events
   // Buttons fire on press only; switches fire on either edge. Switch sw<k>
   // lands in hardware_value bit 7-k.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ev
         assign edge_ev[gi]     = stable_all[gi] & ~stable_dly_reg[gi];
         assign edge_ev[7 - gi] = stable_all[4 + gi] ^ stable_dly_reg[4 + gi];
      end
   endgenerate

`ifdef HW_INPUT_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

   generate
      for (gi = 0; gi < 4; gi++) begin : g_rep
         logic             held;
         logic [CNT_W-1:0] rep_cnt_reg;

         // held rises on the same edge the press event is registered, so the
         // first repeat lands REPEAT_CYCLES cycles after the press event.
         assign held = stable_all[gi] & stable_dly_reg[gi];

         always_ff @(posedge clk) begin
            if (reset || !held) begin
               rep_cnt_reg <= '0;
            end else if (rep_cnt_reg == REP_LAST) begin
               rep_cnt_reg <= '0;
            end else begin
               rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end
         end

         assign rep_ev[gi] = held && (rep_cnt_reg == REP_LAST);
      end
   endgenerate

   assign rep_ev[7:4] = 4'b0000;
`else
   assign rep_ev = 8'h00;
`endif

   // ------------------------------------------------------- pending + handshake
   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t     state_reg, state_next;
   logic [7:0] value_reg, value_next;
   logic [7:0] pending_reg, pending_next;
   logic       overrun_reg, overrun_next;
   logic [7:0] clear_bits;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         value_reg   <= 8'h00;
         pending_reg <= 8'h00;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         value_reg   <= value_next;
         pending_reg <= pending_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      value_next = value_reg;
      clear_bits = 8'h00;
      case (state_reg)
         ST_IDLE: begin
            if (pending_reg != 8'h00) begin
               // Isolate the lowest set bit: wb has the highest priority.
               value_next = pending_reg & (~pending_reg + 8'd1);
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hw_ack) begin
               clear_bits = value_reg;
               value_next = 8'h00;
               state_next = ST_IDLE;
            end
         end
         default: begin
            value_next = 8'h00;
            state_next = ST_IDLE;
         end
      endcase

      // A new event in the ack cycle wins over the clear and is not an overrun.
      // Repeat events merge silently and never flag overrun.
      pending_next = (pending_reg & ~clear_bits) | edge_ev | rep_ev;
      overrun_next = overrun_reg | (|(edge_ev & pending_reg & ~clear_bits));
   end

   assign hardware_value = value_reg;
   assign hw_valid       = (state_reg == ST_HOLD);
   assign overrun        = overrun_reg;

endmodule

// File: doc/hw_input_conditioner.md
Name: hw_input_conditioner

Overview:
- Upstream feeder of the hardware-value decoder.
- Synchronises and debounces the four raw push-buttons (wb, sb, eb, nb) and four slide switches (sw3..sw0), and turns them into discrete events.
- Queues events as pending bits and presents them one at a time as an 8-bit one-hot hardware_value under a valid/ack handshake.
- The decoder consumes hardware_value and returns ack once it has used the value.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its stable value before the stable value flips; legal range 2..65535.
- CNT_W, 16: debounce/repeat counter width; must hold DEBOUNCE_CYCLES-1 and REPEAT_CYCLES-1.
- REPEAT_CYCLES, 1000: auto-repeat period in cycles; used only when AUTO_REPEAT_EN is defined.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where reset=1.
- raw_btn  in  4  asynchronous buttons: [0]=wb [1]=sb [2]=eb [3]=nb; 1 = pressed.
- raw_sw  in  4  asynchronous switches: [n]=swn.
- hw_ack  in  1  consumer accepted the current hardware_value.
- hardware_value  out  8  one-hot event to decoder: b0 wb, b1 sb, b2 eb, b3 nb, b4 sw3, b5 sw2, b6 sw1, b7 sw0; 8'h00 when hw_valid=0.
- hw_valid  out  1  hardware_value holds an event.
- sw_level  out  4  debounced switch levels, same indexing as raw_sw.
- overrun  out  1  sticky; set when an event hits an already-pending bit.

Behaviour:
- Reset: hardware_value=0, hw_valid=0, sw_level=0, overrun=0. Sync flops, stable values, counters, pending bits and FSM (IDLE) all cleared. Reset mid-handshake drops the presented event and all pending events.
- Sync: two-flop synchroniser per raw bit; s2 is the synchronised value.
- Debounce, per bit:
  - s2==stable: counter<=0.
  - s2!=stable and counter==DEBOUNCE_CYCLES-1: stable<=s2, counter<=0.
  - Otherwise: counter+1.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected; a mismatch interrupted by one matching cycle restarts the count.
- Events, registered one cycle after the stable flip:
  - Buttons: rising edge of stable only; releases generate no event.
  - Switches: either edge of stable. sw_level updates in the same cycle as the switch's stable value.
  - Each event sets its pending bit. If that bit is already pending, overrun<=1; the event merges and no counter is kept.
- FSM:
  - IDLE: if pending!=0, latch the lowest-index set pending bit (mapping order b0..b7 above, so wb is highest priority) into hardware_value, set hw_valid=1, go to HOLD. Otherwise remain in IDLE with outputs 0.
  - HOLD: hardware_value and hw_valid are stable. On hw_ack=1: clear that pending bit, hardware_value<=0, hw_valid<=0 next edge, go to IDLE.
  - One-cycle bubble minimum between consecutive events. hw_ack in IDLE is ignored.
- Simultaneous set and clear on the same pending bit (new event in the ack cycle): set wins. The bit stays pending and is re-presented after the bubble; overrun is not set.
- Priority is evaluated only in IDLE. A higher-priority event arriving during HOLD does not pre-empt the presented event.
- Latency: raw edge first sampled at edge 1 → stable flips at edge 2+DEBOUNCE_CYCLES → pending at edge 3+DEBOUNCE_CYCLES → hw_valid=1 after edge 4+DEBOUNCE_CYCLES when the FSM is IDLE with nothing else pending.
- overrun clears only on reset.

Optional Feature:
- Macro: HW_INPUT_AUTO_REPEAT_EN.
- Defined: while a button's stable value stays 1, a per-button repeat counter runs. It generates a new press event every REPEAT_CYCLES cycles, with the first repeat REPEAT_CYCLES cycles after the initial press event. The counter resets on release or reset. Repeat events into an already-pending bit merge silently and do not set overrun.
- Undefined: no repeat counters exist; one event per press.

Test Plan:
- DEBOUNCE_CYCLES=4, reset then raw_btn=4'b0001 held → hardware_value=8'h01 and hw_valid=1 after edge 8. Hold without ack for 20 cycles: value unchanged. hw_ack pulse → hw_valid=0 next edge; no further event.
- DEBOUNCE_CYCLES=4, raw_btn[2] pulses high for 3 cycles, then low → no event; counter resets; hw_valid stays 0.
- raw_sw[0] 0→1, later 1→0 (each held ≥8 cycles), ack each → two events of 8'h80; sw_level[0] follows 1 then 0.
- raw_btn=4'b1000 and raw_sw[3]=1 settle on the same cycle → first 8'h08, ack, one idle cycle, then 8'h10.
- Press and release wb twice while the first wb event is unacked → overrun=1; after ack, no second wb event. Press wb so its event lands in the ack cycle → wb re-presented, overrun unchanged.
- Assert reset during HOLD with two events pending → next cycle hw_valid=0, hardware_value=0, overrun=0; no events after reset deasserts.
